alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: RR_EN, default 1, 1 = round-robin arbitration, 0 = fixed priority (requester 0 wins).
REQ-002 clk  in  1  single clock; all state updates on rising edge.
REQ-003 reset_n  in  1  reset, asynchronous and active-low.
REQ-004 req0_valid  in  1  requester 0 has an operation pending.
REQ-005 req0_ready  out  1  requester 0 operation accepted this cycle when high with req0_valid.
REQ-006 req0_a, req0_b  in  4 each  requester 0 operands.
REQ-007 req0_op  in  2  requester 0 ALU control code: 00 add, 01 sub, 10 AND, 11 OR.
REQ-008 req1_valid, req1_ready, req1_a, req1_b, req1_op  same widths and meanings as REQ-004..007, for requester 1.
REQ-009 rsp_valid  out  1  response held for consumer.
REQ-010 rsp_ready  in  1  consumer accepts response.
REQ-011 rsp_id  out  1  requester index owning the response.
REQ-012 rsp_result  out  4  captured ALU result.
REQ-013 rsp_flags  out  4  captured ALU flags: [3] overflow, [2] carry, [1] negative, [0] zero.
REQ-014 alu_a, alu_b  out  4 each  operands to the shared combinational ALU.
REQ-015 alu_ctrl  out  2  control code to the shared ALU.
REQ-016 alu_result  in  4; alu_flags  in  4  ALU outputs, combinational from alu_a/alu_b/alu_ctrl.
REQ-017 busy  out  1  high in any state other than IDLE.

Function
REQ-018 FSM states: IDLE, EXEC, RESP; exactly one active.
REQ-019 IDLE: if any reqN_valid, assert reqN_ready for exactly one granted requester, combinationally; no ready asserted when no valid.
REQ-020 Arbitration, single valid: that requester is granted.
REQ-021 Arbitration, both valid, RR_EN=1: grant the requester not equal to last_id; RR_EN=0: grant requester 0.
REQ-022 On valid&ready in IDLE: latch a, b, op, id into operation registers; last_id <= granted id; next state EXEC.
REQ-023 reqN_ready SHALL be 0 in EXEC and RESP; requests are not queued, requesters hold valid/operands until ready.
REQ-024 alu_a, alu_b, alu_ctrl SHALL be driven only from the operation registers (never directly from request ports).
REQ-025 EXEC lasts exactly one cycle; at its closing edge capture alu_result into rsp_result, alu_flags into rsp_flags verbatim, operation id into rsp_id; next state RESP.
REQ-026 RESP: rsp_valid=1; rsp_result, rsp_flags, rsp_id stable until accepted.
REQ-027 RESP with rsp_ready=1: next state IDLE, rsp_valid low next cycle; with rsp_ready=0: remain in RESP indefinitely.
REQ-028 Latency: acceptance edge to rsp_valid high = 2 cycles; minimum issue interval 3 cycles per operation.
REQ-029 rsp_ready outside RESP SHALL be ignored.
REQ-030 A requester dropping valid in IDLE before acceptance SHALL simply not be granted; no state change.

Reset
REQ-031 reset_n low SHALL immediately force IDLE, regardless of clock, including mid-EXEC or mid-RESP; in-flight operation discarded.
REQ-032 Reset values: operation registers 0 (alu_a=0, alu_b=0, alu_ctrl=00), rsp_result=0, rsp_flags=0, rsp_id=0, rsp_valid=0, busy=0, last_id=1 (requester 0 wins the first tie).
REQ-033 After reset_n rises, the first grant SHALL occur no earlier than the first rising edge with reset_n high.

Verification
REQ-034 Req0 add a=3 b=4, rsp_ready=1 -> req0_ready in IDLE, rsp_valid 2 cycles after accept, rsp_id=0, rsp_result=0111, rsp_flags=0000.
REQ-035 Req1 sub a=5 b=5 -> rsp_id=1, rsp_result=0000, rsp_flags=0101 (carry, zero).
REQ-036 Both valid continuously, RR_EN=1, 4 ops -> grant order 0,1,0,1; with RR_EN=0 -> 0,0,0,0.
REQ-037 rsp_ready held 0 for 5 cycles in RESP -> rsp_valid, result, flags, id stable; no reqN_ready asserted; IDLE one cycle after rsp_ready=1.
REQ-038 reset_n pulsed low during EXEC -> rsp_valid=0, busy=0 immediately; no response ever issued for that operation; next tie grants requester 0.
REQ-039 Req0 AND a=1100 b=0011 then OR a=1100 b=0011 -> rsp_result 0000 then 1111; alu_ctrl observed 10 then 11 during respective EXEC cycles.

Source files
------------

// File: rtl/alu_arbiter.sv
// alu_arbiter: two-requester arbiter in front of a shared external combinational ALU
module alu_arbiter #(
    parameter bit RR_EN = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req0_valid,
    output logic       req0_ready,
    input  logic [3:0] req0_a,
    input  logic [3:0] req0_b,
    input  logic [1:0] req0_op,
    input  logic       req1_valid,
    output logic       req1_ready,
    input  logic [3:0] req1_a,
    input  logic [3:0] req1_b,
    input  logic [1:0] req1_op,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic       rsp_id,
    output logic [3:0] rsp_result,
    output logic [3:0] rsp_flags,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [1:0] alu_ctrl,
    input  logic [3:0] alu_result,
    input  logic [3:0] alu_flags,
    output logic       busy
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t state;
    logic   last_id;
    logic   op_id;
    logic   pick1;

    // Requester 1 wins when alone, or on a tie when round-robin says it is its turn
    always_comb begin
        pick1      = req1_valid && (!req0_valid || (RR_EN && !last_id));
        req1_ready = (state == IDLE) && pick1;
        req0_ready = (state == IDLE) && req0_valid && !pick1;
    end

    // Operation sequencing: latch the winner, let the ALU settle for one cycle, hold the response
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            last_id    <= 1'b1;
            op_id      <= 1'b0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_ctrl   <= '0;
            rsp_result <= '0;
            rsp_flags  <= '0;
            rsp_id     <= 1'b0;
            rsp_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req0_ready || req1_ready) begin
                    alu_a    <= pick1 ? req1_a : req0_a;
                    alu_b    <= pick1 ? req1_b : req0_b;
                    alu_ctrl <= pick1 ? req1_op : req0_op;
                    op_id    <= pick1;
                    last_id  <= pick1;
                    busy     <= 1'b1;
                    state    <= EXEC;
                end
                EXEC: begin
                    rsp_result <= alu_result;
                    rsp_flags  <= alu_flags;
                    rsp_id     <= op_id;
                    rsp_valid  <= 1'b1;
                    state      <= RESP;
                end
                RESP: if (rsp_ready) begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    rsp_valid <= 1'b0;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end
endmodule
